// File: rtl/skolem_chk_pkg.sv
// Shared types and defaults for the bvsge/bvneg Skolem self-check stage.
// Contents: checker state enum, default widths, bit-index width helper.
package skolem_chk_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to index WIDTH operand bits (at least one bit).
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_neg_sge_step.sv
// One LSB-first bit step of bvsge(bvneg(x), t).
// Ports: x_bit/t_bit  current operand bits
//        carry/lt     running negation carry and "lower bits of -x < t" flag
//        is_msb       current bit is the sign bit
//        n_bit        bit of -x; carry_next/lt_next updated running state
//        holds_msb    signed verdict, valid only when is_msb (else 0)
module serial_neg_sge_step (
    input  logic x_bit,
    input  logic t_bit,
    input  logic carry,
    input  logic lt,
    input  logic is_msb,
    output logic n_bit,
    output logic carry_next,
    output logic lt_next,
    output logic holds_msb
);

    // -x = ~x + 1: ripple the +1 through the inverted bits.
    assign n_bit      = ~x_bit ^ carry;
    assign carry_next = ~x_bit & carry;

    // Unsigned compare of the bits seen so far, higher bit dominates.
    assign lt_next = (~n_bit & t_bit) | (~(n_bit ^ t_bit) & lt);

    // Differing sign bits: -x >= t exactly when t is the negative one.
    assign holds_msb = is_msb & ((n_bit != t_bit) ? t_bit : ~lt_next);

endmodule

// File: rtl/skolem_inv_sge_neg_checker.sv
// Bit-serial checker: verdict holds = ((-x) >=s t), plus neg_out = -x.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready/x_in/t_in     request handshake and operands
//        out_valid/out_ready/holds/neg_out verdict handshake and results
//        pass_cnt/fail_cnt               saturating verdict counters,
//                                        only with SKOLEM_CHK_STATS_EN
module skolem_inv_sge_neg_checker
    import skolem_chk_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] t_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             holds,
    output logic [WIDTH-1:0] neg_out
`ifdef SKOLEM_CHK_STATS_EN
    ,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`endif
);

    localparam int unsigned IDX_W = idx_width(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("WIDTH must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t             state, state_nx;
    logic [WIDTH-1:0]   x_sr, x_sr_nx;
    logic [WIDTH-1:0]   t_sr, t_sr_nx;
    logic [WIDTH-1:0]   neg_out_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic               carry, carry_nx;
    logic               lt, lt_nx;
    logic               holds_nx, in_ready_nx, out_valid_nx;

    logic               is_msb;
    logic               n_bit, carry_step, lt_step, holds_step;

    assign is_msb = (idx == IDX_W'(WIDTH - 1));

    serial_neg_sge_step u_step (
        .x_bit      (x_sr[0]),
        .t_bit      (t_sr[0]),
        .carry      (carry),
        .lt         (lt),
        .is_msb     (is_msb),
        .n_bit      (n_bit),
        .carry_next (carry_step),
        .lt_next    (lt_step),
        .holds_msb  (holds_step)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_sr      <= '0;
            t_sr      <= '0;
            neg_out   <= '0;
            idx       <= '0;
            carry     <= 1'b1;
            lt        <= 1'b0;
            holds     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            x_sr      <= x_sr_nx;
            t_sr      <= t_sr_nx;
            neg_out   <= neg_out_nx;
            idx       <= idx_nx;
            carry     <= carry_nx;
            lt        <= lt_nx;
            holds     <= holds_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        x_sr_nx      = x_sr;
        t_sr_nx      = t_sr;
        neg_out_nx   = neg_out;
        idx_nx       = idx;
        carry_nx     = carry;
        lt_nx        = lt;
        holds_nx     = holds;
        in_ready_nx  = in_ready;
        out_valid_nx = out_valid;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    x_sr_nx     = x_in;
                    t_sr_nx     = t_in;
                    carry_nx    = 1'b1;
                    lt_nx       = 1'b0;
                    idx_nx      = '0;
                    in_ready_nx = 1'b0;
                    state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                x_sr_nx    = x_sr >> 1;
                t_sr_nx    = t_sr >> 1;
                carry_nx   = carry_step;
                lt_nx      = lt_step;
                // After WIDTH shifts bit 0 of -x has reached the LSB.
                neg_out_nx = {n_bit, neg_out[WIDTH-1:1]};
                idx_nx     = idx + IDX_W'(1);
                if (is_msb) begin
                    holds_nx     = holds_step;
                    out_valid_nx = 1'b1;
                    state_nx     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nx = 1'b0;
                    in_ready_nx  = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx     = IDLE;
                in_ready_nx  = 1'b1;
                out_valid_nx = 1'b0;
            end
        endcase
    end

`ifdef SKOLEM_CHK_STATS_EN
    logic verdict_taken;
    assign verdict_taken = (state == DONE) && out_ready;

    // Saturating verdict counters, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (verdict_taken) begin
            if (holds && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
            if (!holds && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_skolem_inv_sge_neg_checker.sv
module tb_skolem_inv_sge_neg_checker;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_in, t_in;
    logic          out_valid;
    logic          out_ready;
    logic          holds;
    logic [W-1:0]  neg_out;
`ifdef SKOLEM_CHK_STATS_EN
    logic [CW-1:0] pass_cnt, fail_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pass_m = 0;
    int fail_m = 0;

    skolem_inv_sge_neg_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .t_in      (t_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .holds     (holds),
        .neg_out   (neg_out)
`ifdef SKOLEM_CHK_STATS_EN
        ,
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic.
    function automatic logic [W-1:0] ref_neg(input logic [W-1:0] x);
        return W'(0) - x;
    endfunction

    function automatic logic ref_holds(input logic [W-1:0] x, input logic [W-1:0] t);
        logic signed [W-1:0] n, ts;
        n  = ref_neg(x);
        ts = t;
        return n >= ts;
    endfunction

    task automatic check_stats();
`ifdef SKOLEM_CHK_STATS_EN
        check("pass_cnt", 32'(pass_cnt), 32'(pass_m));
        check("fail_cnt", 32'(fail_cnt), 32'(fail_m));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pass_m = 0;
        fail_m = 0;
    endtask

    // One transaction; garbage in_valid is driven while busy to prove it is ignored.
    task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] t, input int bp);
        int            cnt;
        logic          eh;
        logic [W-1:0]  en;
        eh = ref_holds(x, t);
        en = ref_neg(x);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x_in = x;
        t_in = t;
        @(negedge clk);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            x_in = W'($urandom);
            t_in = W'($urandom);
            @(negedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'(W));
        check("holds", 32'(holds), 32'(eh));
        check("neg_out", 32'(neg_out), 32'(en));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_holds", 32'(holds), 32'(eh));
            check("bp_neg", 32'(neg_out), 32'(en));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
        if (eh) pass_m = (pass_m < (1 << CW) - 1) ? pass_m + 1 : pass_m;
        else    fail_m = (fail_m < (1 << CW) - 1) ? fail_m + 1 : fail_m;
        check_stats();
    endtask

    initial begin
        logic [W-1:0] rx, rt;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = '0;
        t_in = '0;
        do_reset();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_holds", 32'(holds), 32'd0);
        check("rst_neg_out", 32'(neg_out), 32'd0);
        check_stats();

        run_txn(4'b0001, 4'b1111, 0);
        run_txn(4'b0001, 4'b0000, 0);
        run_txn(4'b0000, 4'b0000, 1);
        run_txn(4'b1000, 4'b0111, 0);
        run_txn(4'b1000, 4'b1000, 2);
        run_txn(4'b0110, 4'b1010, 5);

        // Reset at idx=2 drops the transaction.
        in_valid = 1'b1;
        x_in = 4'b0101;
        t_in = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pass_m = 0;
        fail_m = 0;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("mid_rst_no_verdict", 32'(out_valid), 32'd0);
        end
        check_stats();
        run_txn(4'b0011, 4'b1100, 0);

        // Reset and in_valid together: nothing accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        pass_m = 0;
        fail_m = 0;
        check("rst_vs_valid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("rst_vs_valid_idle", 32'(in_ready), 32'd1);

`ifdef SKOLEM_CHK_STATS_EN
        for (int i = 0; i < 4; i++) run_txn(4'b0000, 4'b0000, 0);
        check("stats_pass_sat", 32'(pass_cnt), 32'd3);
        run_txn(4'b0001, 4'b0000, 0);
        check("stats_fail_one", 32'(fail_cnt), 32'd1);
        check("stats_pass_hold", 32'(pass_cnt), 32'd3);
`endif

        for (int i = 0; i < 60; i++) begin
            rx = W'($urandom);
            rt = W'($urandom);
            run_txn(rx, rt, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skolem_inv_sge_neg_checker.md
Name: skolem_inv_sge_neg_checker

Overview:
- Consumer-side counterpart to the bvsge/bvneg invertibility Skolem generators.
- Accepts a candidate witness x and bound t over a valid/ready handshake.
- Evaluates bvsge(bvneg(x), t) bit-serially, LSB first, one bit per clock.
- Returns a pass/fail verdict plus the computed negation; used as the on-chip self-check stage behind generated Skolem blocks.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- CNT_W, 16, width of optional statistics counters.

Ports:
- clk  input  1  clock, all state rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  x_in/t_in valid
- in_ready  output  1  checker can accept a transaction
- x_in  input  WIDTH  candidate witness x
- t_in  input  WIDTH  bound t, signed two's complement
- out_valid  output  1  verdict valid
- out_ready  input  1  downstream accepts verdict
- holds  output  1  1 iff (-x) >=s t
- neg_out  output  WIDTH  computed -x mod 2^WIDTH
- pass_cnt  output  CNT_W  present only with SKOLEM_CHK_STATS_EN
- fail_cnt  output  CNT_W  present only with SKOLEM_CHK_STATS_EN

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, holds=0, neg_out=0, carry=1, lt=0, bit index=0, counters=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x_in and t_in into shift registers, set carry=1, lt=0, idx=0, go to SHIFT.
- SHIFT, one bit k=idx per cycle, in_ready=0:
  - n_k = ~x[k] ^ carry; carry' = ~x[k] & carry.
  - n_k is shifted into neg_out from the MSB side.
  - For k<WIDTH-1: lt' = (~n_k & t[k]) | (~(n_k^t[k]) & lt).
  - For k=WIDTH-1 (signed step): if n_k != t[k], holds = t[k] (neg is non-negative); else holds = ~lt'. Then go to DONE.
- DONE:
  - out_valid=1; holds and neg_out stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
- Latency and throughput:
  - Accept on edge E0; out_valid rises WIDTH cycles after E0 (SHIFT lasts exactly WIDTH cycles).
  - Minimum issue interval is WIDTH+2 cycles; no overlap of transactions.
- Arithmetic rules:
  - Negation wraps mod 2^WIDTH: x=100..0 gives neg=100..0; x=0 gives neg=0. The final carry is discarded.
- in_valid is ignored outside IDLE. x_in/t_in are sampled only at the accept edge.
- out_ready is ignored outside DONE.
- rst in any state: next cycle is IDLE with reset values, and any in-flight transaction is dropped without a verdict.
- rst and in_valid in the same cycle: reset wins, nothing is accepted.

Optional Feature:
- Macro SKOLEM_CHK_STATS_EN.
- Defined:
  - pass_cnt/fail_cnt ports exist.
  - At each DONE&&out_ready handshake, increment pass_cnt if holds=1, else fail_cnt.
  - Counters saturate at all-ones; reset to 0 by rst only.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package skolem_chk_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - DEFAULT_WIDTH=4, DEFAULT_CNT_W=16
  - function clog2-based index width helper
- Sub-module serial_neg_sge_step: purely combinational single-bit step.
  - Inputs: x_bit, t_bit, carry, lt, is_msb.
  - Outputs: n_bit, carry_next, lt_next, holds_msb.
  - Instantiated once; the FSM, shift registers and handshake stay in the top module.

Test Plan (WIDTH=4):
- x=0001, t=1111 -> neg_out=1111, holds=1 (-1 >= -1); out_valid asserted exactly 4 cycles after the accept edge.
- x=0001, t=0000 -> neg_out=1111, holds=0; x=0000, t=0000 -> neg_out=0000, holds=1.
- Wrap-around: x=1000, t=0111 -> neg_out=1000, holds=0; x=1000, t=1000 -> holds=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_valid, holds, neg_out stable; in_ready=0 throughout; a new in_valid is not accepted until 1 cycle after the out_ready handshake.
- Reset mid-SHIFT: assert rst at idx=2.
  - Required: next cycle in_ready=1, out_valid=0, no verdict emitted; the next transaction (x=0011, t=1100) yields neg_out=1101, holds=1.
- With SKOLEM_CHK_STATS_EN, CNT_W=2: 4 passing transactions -> pass_cnt=3 (saturated), fail_cnt=0; one failing -> fail_cnt=1.
